// File: rtl/param_bus_mux_pkg.sv
// param_bus_mux_pkg: arbitration mode type and rotating-priority pick helper
package param_bus_mux_pkg;
  typedef enum logic {ARB_FIXED, ARB_ROUNDROBIN} arb_mode_e;
  localparam int MAX_SLAVES = 16;
  function automatic logic [3:0] rotate_pick(input logic [MAX_SLAVES-1:0] req, input logic [3:0] start, input int n);
    logic [3:0] pick;
    logic found;
    int idx;
    pick = '0;
    found = 1'b0;
    for (int i = 0; i < MAX_SLAVES; i++) begin
      idx = (int'(start) + i) % n;
      if (i < n && !found && req[4'(idx)]) begin
        pick = 4'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction
endpackage

// File: rtl/param_bus_mux_id_fifo.sv
// param_bus_mux_id_fifo: in-order queue of granted slave indices awaiting responses
module param_bus_mux_id_fifo #(
  parameter int W = 2,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW:0] wp, rp;
  assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign empty = wp == rp;
  assign head = mem[rp[AW-1:0]];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push && !full) wp <= wp + 1'b1;
      if (pop && !empty) rp <= rp + 1'b1;
    end
  always_ff @(posedge clk)
    if (push && !full) mem[wp[AW-1:0]] <= din;
endmodule

// File: rtl/param_bus_mux.sv
// param_bus_mux: N-to-1 request arbiter with in-order response routing back to requesters
module param_bus_mux
  import param_bus_mux_pkg::*;
#(
  parameter int        N_SLAVES        = 4,
  parameter int        ADDR_W          = 32,
  parameter int        DATA_W          = 32,
  parameter arb_mode_e ARB_MODE        = ARB_ROUNDROBIN,
  parameter int        MAX_OUTSTANDING = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic [N_SLAVES-1:0]        i_req_valid,
  output logic [N_SLAVES-1:0]        o_req_ready,
  input  logic [N_SLAVES-1:0]        i_req_write,
  input  logic [N_SLAVES*ADDR_W-1:0] i_req_addr,
  input  logic [N_SLAVES*DATA_W-1:0] i_req_wdata,
  output logic [N_SLAVES-1:0]        o_resp_valid,
  input  logic [N_SLAVES-1:0]        i_resp_ready,
  output logic [N_SLAVES*DATA_W-1:0] o_resp_rdata,
  output logic                       o_m_req_valid,
  input  logic                       i_m_req_ready,
  output logic                       o_m_req_write,
  output logic [ADDR_W-1:0]          o_m_req_addr,
  output logic [DATA_W-1:0]          o_m_req_wdata,
  input  logic                       i_m_resp_valid,
  output logic                       o_m_resp_ready,
  input  logic [DATA_W-1:0]          i_m_resp_rdata,
  output logic                       o_resp_error
);
  localparam int IW = $clog2(N_SLAVES);
  logic [IW-1:0] rr_ptr, lock_idx, grant, head;
  logic locked, full, empty, push, pop;
  // outputs are gated by i_rst_n so they drop the instant reset asserts
  assign grant = locked ? lock_idx :
                 IW'(rotate_pick(16'(i_req_valid), ARB_MODE == ARB_ROUNDROBIN ? 4'(rr_ptr) : 4'd0, N_SLAVES));
  assign o_m_req_valid = i_rst_n && |i_req_valid && !full;
  assign push = o_m_req_valid && i_m_req_ready;
  assign o_req_ready = {{(N_SLAVES-1){1'b0}}, push} << grant;
  assign o_m_req_write = i_req_write[grant];
  assign o_m_req_addr = i_req_addr[int'(grant)*ADDR_W +: ADDR_W];
  assign o_m_req_wdata = i_req_wdata[int'(grant)*DATA_W +: DATA_W];
  assign o_resp_valid = {{(N_SLAVES-1){1'b0}}, i_m_resp_valid && !empty} << head;
  assign o_resp_rdata = {N_SLAVES{i_m_resp_rdata}};
  assign o_m_resp_ready = empty ? i_m_resp_valid && i_rst_n : i_resp_ready[head];
  assign pop = i_m_resp_valid && !empty && i_resp_ready[head];
  param_bus_mux_id_fifo #(.W(IW), .DEPTH(MAX_OUTSTANDING)) u_fifo (
    .clk(i_clk),
    .rst_n(i_rst_n),
    .push(push),
    .pop(pop),
    .din(grant),
    .head(head),
    .full(full),
    .empty(empty)
  );
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      locked <= 1'b0;
      lock_idx <= '0;
      rr_ptr <= '0;
      o_resp_error <= 1'b0;
    end else begin
      locked <= o_m_req_valid && !i_m_req_ready;
      if (o_m_req_valid) lock_idx <= grant;
      if (push && ARB_MODE == ARB_ROUNDROBIN) rr_ptr <= grant == IW'(N_SLAVES-1) ? '0 : grant + 1'b1;
      if (i_m_resp_valid && empty) o_resp_error <= 1'b1;
    end
endmodule

// File: tb/tb_param_bus_mux.sv
// tb_param_bus_mux: checks round-robin and fixed-priority instances against a queue-based model
module tb_param_bus_mux;
  import param_bus_mux_pkg::*;
  logic clk = 1'b0;
  logic rst_n;
  logic [3:0] req_valid, req_write, resp_ready;
  logic [127:0] req_addr, req_wdata;
  logic m_req_ready, m_resp_valid;
  logic [31:0] m_resp_rdata;
  logic [3:0] a_rdy, a_rv, f_rdy, f_rv;
  logic [127:0] a_rd, f_rd;
  logic a_mv, a_wr, a_mrr, a_err, f_mv, f_wr, f_mrr, f_err;
  logic [31:0] a_addr, a_wd, f_addr, f_wd;
  int total = 0;
  int bad = 0;
  int qd[2][16];
  int qn[2];
  int rr[2];
  bit lk[2];
  int li[2];
  bit er[2];

  always #5 clk = ~clk;

  param_bus_mux #(.ARB_MODE(ARB_ROUNDROBIN)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_valid(req_valid), .o_req_ready(a_rdy), .i_req_write(req_write),
    .i_req_addr(req_addr), .i_req_wdata(req_wdata),
    .o_resp_valid(a_rv), .i_resp_ready(resp_ready), .o_resp_rdata(a_rd),
    .o_m_req_valid(a_mv), .i_m_req_ready(m_req_ready), .o_m_req_write(a_wr),
    .o_m_req_addr(a_addr), .o_m_req_wdata(a_wd),
    .i_m_resp_valid(m_resp_valid), .o_m_resp_ready(a_mrr), .i_m_resp_rdata(m_resp_rdata),
    .o_resp_error(a_err)
  );

  param_bus_mux #(.ARB_MODE(ARB_FIXED)) dut_f (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_valid(req_valid), .o_req_ready(f_rdy), .i_req_write(req_write),
    .i_req_addr(req_addr), .i_req_wdata(req_wdata),
    .o_resp_valid(f_rv), .i_resp_ready(resp_ready), .o_resp_rdata(f_rd),
    .o_m_req_valid(f_mv), .i_m_req_ready(m_req_ready), .o_m_req_write(f_wr),
    .o_m_req_addr(f_addr), .o_m_req_wdata(f_wd),
    .i_m_resp_valid(m_resp_valid), .o_m_resp_ready(f_mrr), .i_m_resp_rdata(m_resp_rdata),
    .o_resp_error(f_err)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // instance 0 is round-robin, instance 1 is fixed priority
  function automatic int pick_m(input int k);
    int s;
    if (lk[k]) return li[k];
    for (int i = 0; i < 4; i++) begin
      s = k == 1 ? i : (rr[k] + i) % 4;
      if (req_valid[s]) return s;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      qn[k] = 0;
      rr[k] = 0;
      lk[k] = 0;
      li[k] = 0;
      er[k] = 0;
    end
  endtask

  task automatic check_inst(input int k, input logic mv, input logic [3:0] rdy, input logic [31:0] addr,
                            input logic [31:0] wd, input logic wr, input logic [3:0] rv,
                            input logic [127:0] rd, input logic mrr, input logic err);
    int g, h;
    bit emv;
    string p;
    p = k == 0 ? "rr" : "fix";
    g = pick_m(k);
    emv = rst_n && g >= 0 && qn[k] < 4;
    h = qn[k] > 0 ? qd[k][0] : -1;
    chk({p, ".m_req_valid"}, 32'(mv), 32'(emv));
    chk({p, ".req_ready"}, 32'(rdy), (emv && m_req_ready) ? 32'(1 << g) : 32'd0);
    if (emv) begin
      chk({p, ".m_req_addr"}, addr, req_addr[g*32 +: 32]);
      chk({p, ".m_req_wdata"}, wd, req_wdata[g*32 +: 32]);
      chk({p, ".m_req_write"}, 32'(wr), 32'(req_write[g]));
    end
    chk({p, ".resp_valid"}, 32'(rv), (h >= 0 && m_resp_valid) ? 32'(1 << h) : 32'd0);
    if (h >= 0 && m_resp_valid) chk({p, ".resp_rdata"}, rd[h*32 +: 32], m_resp_rdata);
    chk({p, ".m_resp_ready"}, 32'(mrr), 32'(rst_n && (h < 0 ? m_resp_valid : resp_ready[h])));
    chk({p, ".resp_error"}, 32'(err), 32'(er[k]));
  endtask

  always @(negedge clk) begin
    if (!rst_n) model_reset();
    check_inst(0, a_mv, a_rdy, a_addr, a_wd, a_wr, a_rv, a_rd, a_mrr, a_err);
    check_inst(1, f_mv, f_rdy, f_addr, f_wd, f_wr, f_rv, f_rd, f_mrr, f_err);
  end

  always @(posedge clk)
    if (rst_n)
      for (int k = 0; k < 2; k++) begin
        int g, h;
        bit emv, push, pop;
        g = pick_m(k);
        emv = g >= 0 && qn[k] < 4;
        push = emv && m_req_ready;
        h = qn[k] > 0 ? qd[k][0] : -1;
        pop = h >= 0 && m_resp_valid && resp_ready[h];
        if (h < 0 && m_resp_valid) er[k] = 1;
        if (pop) begin
          for (int i = 0; i < 15; i++) qd[k][i] = qd[k][i+1];
          qn[k]--;
        end
        if (push) begin
          qd[k][qn[k]] = g;
          qn[k]++;
          lk[k] = 0;
          if (k == 0) rr[k] = (g + 1) % 4;
        end else if (emv) begin
          lk[k] = 1;
          li[k] = g;
        end
      end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int rr_seq[4];
    int ord[4];
    rr_seq = '{0, 1, 2, 3};
    ord = '{0, 2, 1, 3};
    rst_n = 1'b0;
    req_valid = 4'hF;
    req_write = 4'b0101;
    req_addr = {32'h1030, 32'h1020, 32'h1010, 32'h1000};
    req_wdata = {32'hA003, 32'hA002, 32'hA001, 32'hA000};
    resp_ready = 4'hF;
    m_req_ready = 1'b1;
    m_resp_valid = 1'b1;
    m_resp_rdata = 32'hD0;
    @(negedge clk);
    chk("rst.m_req_valid", 32'(a_mv), 0);
    chk("rst.req_ready", 32'(a_rdy), 0);
    chk("rst.m_resp_ready", 32'(a_mrr), 0);
    chk("rst.resp_error", 32'(a_err), 0);
    nxt();
    rst_n = 1'b1;
    m_resp_valid = 1'b0;
    // round-robin sweep across all four slaves until the FIFO fills
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rr.sweep_addr", a_addr, 32'h1000 + 32'(rr_seq[i]) * 32'h10);
      chk("fix.always0_addr", f_addr, 32'h1000);
      nxt();
    end
    m_resp_valid = 1'b1;
    m_resp_rdata = 32'hD1;
    @(negedge clk);
    chk("full.block_rr", 32'(a_mv), 0);
    chk("full.block_fix", 32'(f_mv), 0);
    chk("full.pop_slot0", 32'(a_rv), 32'h1);
    nxt();
    m_resp_valid = 1'b0;
    @(negedge clk);
    chk("full.push_after_pop", 32'(a_mv), 1);
    chk("rr.wrap_addr", a_addr, 32'h1000);
    nxt();
    @(negedge clk);
    chk("full.again", 32'(a_mv), 0);
    nxt();
    req_valid = 4'h0;
    m_resp_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rr.drain_order", 32'(a_rv), 32'(1 << ((i + 1) % 4)));
      nxt();
    end
    m_resp_valid = 1'b0;
    // fixed priority starves slave 3 while slave 1 is requesting
    req_valid = 4'b1010;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("fix.starve_addr", f_addr, 32'h1010);
      chk("fix.starve_ready", 32'(f_rdy), 32'b0010);
      chk("rr.alt_addr", a_addr, i == 1 ? 32'h1030 : 32'h1010);
      nxt();
    end
    req_valid = 4'h0;
    m_resp_valid = 1'b1;
    repeat (3) nxt();
    m_resp_valid = 1'b0;
    // lock holds slave 2 while downstream stalls and slave 0 arrives
    req_valid = 4'b0100;
    m_req_ready = 1'b0;
    @(negedge clk);
    chk("lock.first_addr", f_addr, 32'h1020);
    nxt();
    req_valid = 4'b0101;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("lock.hold_fix", f_addr, 32'h1020);
      chk("lock.hold_rr", a_addr, 32'h1020);
      chk("lock.no_ready", 32'(f_rdy), 0);
      nxt();
    end
    m_req_ready = 1'b1;
    @(negedge clk);
    chk("lock.accept_fix", 32'(f_rdy), 32'b0100);
    chk("lock.accept_rr", 32'(a_rdy), 32'b0100);
    nxt();
    @(negedge clk);
    chk("lock.next_fix", f_addr, 32'h1000);
    chk("lock.next_rr", a_addr, 32'h1000);
    nxt();
    req_valid = 4'h0;
    m_resp_valid = 1'b1;
    repeat (2) nxt();
    m_resp_valid = 1'b0;
    // four outstanding in order 0,2,1,3 then in-order return with a stall
    for (int i = 0; i < 4; i++) begin
      req_valid = 4'(1 << ord[i]);
      nxt();
    end
    req_valid = 4'hF;
    @(negedge clk);
    chk("ord.fifth_blocked", 32'(a_mv), 0);
    nxt();
    req_valid = 4'h0;
    m_resp_valid = 1'b1;
    m_resp_rdata = 32'hD4;
    @(negedge clk);
    chk("ord.resp0", 32'(a_rv), 32'b0001);
    chk("ord.rdata0", a_rd[31:0], 32'hD4);
    nxt();
    resp_ready = 4'b1011;
    repeat (2) begin
      @(negedge clk);
      chk("ord.stall_valid", 32'(a_rv), 32'b0100);
      chk("ord.stall_ready", 32'(a_mrr), 0);
      nxt();
    end
    resp_ready = 4'hF;
    @(negedge clk);
    chk("ord.resp2", 32'(a_rv), 32'b0100);
    chk("ord.resp2_ready", 32'(a_mrr), 1);
    nxt();
    @(negedge clk);
    chk("ord.resp1", 32'(a_rv), 32'b0010);
    nxt();
    @(negedge clk);
    chk("ord.resp3", 32'(a_rv), 32'b1000);
    nxt();
    // unexpected response with nothing outstanding
    @(negedge clk);
    chk("err.drop_ready", 32'(a_mrr), 1);
    chk("err.drop_valid", 32'(a_rv), 0);
    chk("err.not_yet", 32'(a_err), 0);
    nxt();
    m_resp_valid = 1'b0;
    @(negedge clk);
    chk("err.set_rr", 32'(a_err), 1);
    chk("err.set_fix", 32'(f_err), 1);
    nxt();
    @(negedge clk);
    chk("err.sticky", 32'(a_err), 1);
    nxt();
    // reset in the middle of traffic
    req_valid = 4'hF;
    repeat (2) nxt();
    m_resp_valid = 1'b1;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mrst.m_req_valid", 32'(a_mv), 0);
    chk("mrst.req_ready", 32'(a_rdy), 0);
    chk("mrst.resp_valid", 32'(a_rv), 0);
    chk("mrst.m_resp_ready", 32'(a_mrr), 0);
    chk("mrst.error_clr", 32'(a_err), 0);
    chk("mrst.fix_valid", 32'(f_mv), 0);
    @(negedge clk);
    nxt();
    rst_n = 1'b1;
    req_valid = 4'h0;
    @(negedge clk);
    chk("mrst.no_stale_resp", 32'(a_rv), 0);
    nxt();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
